// File: rtl/id_ex_stage_pkg.sv
// Shared constants and types for the ID->EX pipeline stage.
// Holds the ALU op encodings and the control bundle, including the bubble default.
package id_ex_stage_pkg;

    localparam logic [3:0] ALU_OP_ADD = 4'd0;

    // Control bits that travel with an instruction from ID into EX.
    typedef struct packed {
        logic       valid;
        logic [3:0] aluop;
        logic       src1_sa;
        logic       src2_imm;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
    } ctrl_t;

    // A bubble does no work and writes nothing back.
    // It still presents a defined ADD to the ALU.
    localparam ctrl_t CTRL_BUBBLE = '{
        valid:     1'b0,
        aluop:     ALU_OP_ADD,
        src1_sa:   1'b0,
        src2_imm:  1'b0,
        reg_write: 1'b0,
        mem_read:  1'b0,
        mem_write: 1'b0
    };

endpackage

// File: rtl/id_ex_stage_if.sv
// Bundle of the decode-side inputs, the bypass buses and the EX-side outputs of the ID->EX stage.
// The slave modport is the stage itself. The master modport is the surrounding pipeline.
interface id_ex_stage_if #(
    parameter int DW = 32,
    parameter int RW = 5
);
    logic          stall;
    logic          flush;

    logic          id_valid;
    logic [3:0]    id_aluop;
    logic [RW-1:0] id_rs_addr;
    logic [RW-1:0] id_rt_addr;
    logic [RW-1:0] id_rd_addr;
    logic [DW-1:0] id_rs_val;
    logic [DW-1:0] id_rt_val;
    logic [15:0]   id_imm;
    logic          id_imm_sext;
    logic [4:0]    id_sa;
    logic          id_src1_sa;
    logic          id_src2_imm;
    logic          id_reg_write;
    logic          id_mem_read;
    logic          id_mem_write;

    logic          exmem_reg_write;
    logic [RW-1:0] exmem_rd;
    logic [DW-1:0] exmem_result;
    logic          memwb_reg_write;
    logic [RW-1:0] memwb_rd;
    logic [DW-1:0] memwb_result;

    logic          ex_valid;
    logic [3:0]    ex_aluop;
    logic [DW-1:0] ex_opnd1;
    logic [DW-1:0] ex_opnd2;
    logic [DW-1:0] ex_store_data;
    logic [RW-1:0] ex_rd;
    logic          ex_reg_write;
    logic          ex_mem_read;
    logic          ex_mem_write;
    logic          load_use_stall;

    modport slave (
        input  stall, flush,
        input  id_valid, id_aluop, id_rs_addr, id_rt_addr, id_rd_addr,
        input  id_rs_val, id_rt_val, id_imm, id_imm_sext, id_sa,
        input  id_src1_sa, id_src2_imm, id_reg_write, id_mem_read, id_mem_write,
        input  exmem_reg_write, exmem_rd, exmem_result,
        input  memwb_reg_write, memwb_rd, memwb_result,
        output ex_valid, ex_aluop, ex_opnd1, ex_opnd2, ex_store_data,
        output ex_rd, ex_reg_write, ex_mem_read, ex_mem_write, load_use_stall
    );

    modport master (
        output stall, flush,
        output id_valid, id_aluop, id_rs_addr, id_rt_addr, id_rd_addr,
        output id_rs_val, id_rt_val, id_imm, id_imm_sext, id_sa,
        output id_src1_sa, id_src2_imm, id_reg_write, id_mem_read, id_mem_write,
        output exmem_reg_write, exmem_rd, exmem_result,
        output memwb_reg_write, memwb_rd, memwb_result,
        input  ex_valid, ex_aluop, ex_opnd1, ex_opnd2, ex_store_data,
        input  ex_rd, ex_reg_write, ex_mem_read, ex_mem_write, load_use_stall
    );

endinterface

// File: rtl/id_ex_stage_fwd_mux.sv
// Operand bypass selector for one register source.
// The younger EX/MEM result beats MEM/WB. Register $0 is never forwarded.
module id_ex_stage_fwd_mux #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic [RW-1:0] addr,
    input  logic [DW-1:0] val,
    input  logic          exmem_reg_write,
    input  logic [RW-1:0] exmem_rd,
    input  logic [DW-1:0] exmem_result,
    input  logic          memwb_reg_write,
    input  logic [RW-1:0] memwb_rd,
    input  logic [DW-1:0] memwb_result,
    output logic [DW-1:0] fwd
);

    // Pick the newest in-flight value for this register, else the value latched at decode.
    always_comb begin
        fwd = val;
        if (addr != '0) begin
            if (exmem_reg_write && (exmem_rd == addr)) begin
                fwd = exmem_result;
            end else if (memwb_reg_write && (memwb_rd == addr)) begin
                fwd = memwb_result;
            end
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID->EX pipeline register with load-use hazard detection and operand forwarding.
// Its outputs drive the EX-stage ALU operands directly.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input logic            clk,
    input logic            rst,
    id_ex_stage_if.slave   bus
);

    ctrl_t         ctrl_q;
    ctrl_t         id_ctrl;
    logic [RW-1:0] rs_addr_q;
    logic [RW-1:0] rt_addr_q;
    logic [RW-1:0] rd_q;
    logic [DW-1:0] rs_val_q;
    logic [DW-1:0] rt_val_q;
    logic [DW-1:0] imm_ext_q;
    logic [4:0]    sa_q;
    logic [DW-1:0] imm_ext;
    logic [DW-1:0] fwd_rs;
    logic [DW-1:0] fwd_rt;
    logic          load_use;

    // Gather the decoded control bits and extend the immediate before latching.
    always_comb begin
        id_ctrl = '{
            valid:     bus.id_valid,
            aluop:     bus.id_aluop,
            src1_sa:   bus.id_src1_sa,
            src2_imm:  bus.id_src2_imm,
            reg_write: bus.id_reg_write,
            mem_read:  bus.id_mem_read,
            mem_write: bus.id_mem_write
        };
        imm_ext = bus.id_imm_sext ? {{(DW-16){bus.id_imm[15]}}, bus.id_imm}
                                  : {{(DW-16){1'b0}}, bus.id_imm};
    end

    // Detect a load in EX whose result the decode slot needs.
    // rt is checked even for immediate forms because it also supplies store data.
    always_comb begin
        load_use = ctrl_q.valid && ctrl_q.mem_read && (rd_q != '0) && bus.id_valid &&
                   ((!bus.id_src1_sa && (bus.id_rs_addr == rd_q)) ||
                    (bus.id_rt_addr == rd_q));
    end

    // Stage register: reset, then flush, then stall hold, then load-use bubble, then normal load.
    always_ff @(posedge clk) begin
        if (rst || bus.flush || (!bus.stall && load_use)) begin
            ctrl_q    <= CTRL_BUBBLE;
            rs_addr_q <= '0;
            rt_addr_q <= '0;
            rd_q      <= '0;
            rs_val_q  <= '0;
            rt_val_q  <= '0;
            imm_ext_q <= '0;
            sa_q      <= '0;
        end else if (!bus.stall) begin
            ctrl_q    <= id_ctrl;
            rs_addr_q <= bus.id_rs_addr;
            rt_addr_q <= bus.id_rt_addr;
            rd_q      <= bus.id_rd_addr;
            rs_val_q  <= bus.id_rs_val;
            rt_val_q  <= bus.id_rt_val;
            imm_ext_q <= imm_ext;
            sa_q      <= bus.id_sa;
        end
    end

    id_ex_stage_fwd_mux #(.DW(DW), .RW(RW)) u_fwd_rs (
        .addr            (rs_addr_q),
        .val             (rs_val_q),
        .exmem_reg_write (bus.exmem_reg_write),
        .exmem_rd        (bus.exmem_rd),
        .exmem_result    (bus.exmem_result),
        .memwb_reg_write (bus.memwb_reg_write),
        .memwb_rd        (bus.memwb_rd),
        .memwb_result    (bus.memwb_result),
        .fwd             (fwd_rs)
    );

    id_ex_stage_fwd_mux #(.DW(DW), .RW(RW)) u_fwd_rt (
        .addr            (rt_addr_q),
        .val             (rt_val_q),
        .exmem_reg_write (bus.exmem_reg_write),
        .exmem_rd        (bus.exmem_rd),
        .exmem_result    (bus.exmem_result),
        .memwb_reg_write (bus.memwb_reg_write),
        .memwb_rd        (bus.memwb_rd),
        .memwb_result    (bus.memwb_result),
        .fwd             (fwd_rt)
    );

    // Select the ALU operands and drive the EX-side outputs.
    always_comb begin
        bus.ex_valid       = ctrl_q.valid;
        bus.ex_aluop       = ctrl_q.aluop;
        bus.ex_opnd1       = ctrl_q.src1_sa ? {{(DW-5){1'b0}}, sa_q} : fwd_rs;
        bus.ex_opnd2       = ctrl_q.src2_imm ? imm_ext_q : fwd_rt;
        bus.ex_store_data  = fwd_rt;
        bus.ex_rd          = rd_q;
        bus.ex_reg_write   = ctrl_q.reg_write;
        bus.ex_mem_read    = ctrl_q.mem_read;
        bus.ex_mem_write   = ctrl_q.mem_write;
        bus.load_use_stall = load_use;
    end

endmodule
